bool_sweep_checker: RTL and testbench

- Synthesizable sequential stimulus generator and response checker for a 4-input boolean function under test, driving its inputs {a,b,c,d}.
- Sweeps all 16 input vectors and compares the gate-level result (fg) against the assign-level result (fa) and a hard-coded oracle truth table.
- Accumulates pass/fail results and reports them once the sweep is done.
- Sits between a top-level harness and the two function implementations.

---
 rtl/bool_sweep_pkg.sv | 17 +
 rtl/bool_vec_compare.sv | 17 +
 rtl/bool_sweep_checker.sv | 115 +++++++++++
 tb/tb_bool_sweep_checker.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bool_sweep_pkg.sv
// Shared types and constants for the 4-input boolean sweep checker.
// Holds the FSM state encoding, the vector count and the reference truth table.
package bool_sweep_pkg;

  localparam int unsigned N_VEC = 16;

  // Bit i is f(vector i) for f = b~c + a~c + cd, with vector i = {a,b,c,d}.
  localparam logic [N_VEC-1:0] DEFAULT_ORACLE = 16'hBBB8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/bool_vec_compare.sv
// Per-vector verdict: compares the gate-level result against the assign-level
// result and against the oracle bit for the vector currently applied.
module bool_vec_compare (
  input  logic fg,
  input  logic fa,
  input  logic oracle_bit,
  output logic mismatch,
  output logic disagree,
  output logic wrong
);

  // NOTE: pure continuous assignments; every output is always driven, so no latch can form.
  assign disagree = fg ^ fa;
  assign wrong    = fg ^ oracle_bit;
  assign mismatch = disagree | wrong;

endmodule

// File: rtl/bool_sweep_checker.sv
// Sweeps all 16 input vectors of a 4-input function, holds each for SETTLE_CYC
// cycles, then checks fg/fa against the oracle and accumulates registered results.
module bool_sweep_checker
  import bool_sweep_pkg::*;
#(
  parameter int unsigned      SETTLE_CYC = 1,
  parameter logic [N_VEC-1:0] ORACLE     = DEFAULT_ORACLE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  vec_out,
  input  logic        fg_in,
  input  logic        fa_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  fail_cnt,
  output logic [15:0] fail_map,
  output logic [3:0]  first_fail_idx,
  output logic        first_fail_valid
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] LAST_IDX    = 4'(N_VEC - 1);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] settle_cnt;

  logic       vec_fail;
  logic       vec_disagree;
  logic       vec_wrong;
  logic       unused_diag;
  logic [4:0] fail_cnt_nxt;

  bool_vec_compare u_cmp (
    .fg         (fg_in),
    .fa         (fa_in),
    .oracle_bit (ORACLE[idx]),
    .mismatch   (vec_fail),
    .disagree   (vec_disagree),
    .wrong      (vec_wrong)
  );

  // The split verdict is kept on the compare block for debug probing only.
  assign unused_diag  = vec_disagree ^ vec_wrong;
  assign fail_cnt_nxt = fail_cnt + 5'(vec_fail);
  assign vec_out      = idx;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      idx              <= '0;
      settle_cnt       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_cnt         <= '0;
      fail_map         <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state            <= ST_SETTLE;
            idx              <= '0;
            settle_cnt       <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_cnt         <= '0;
            fail_map         <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
          end
        end

        ST_SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (vec_fail) begin
            fail_cnt      <= fail_cnt_nxt;
            fail_map[idx] <= 1'b1;
            if (!first_fail_valid) begin
              first_fail_idx   <= idx;
              first_fail_valid <= 1'b1;
            end
          end
          if (idx == LAST_IDX) begin
            // pass is judged on the count including this last vector's verdict.
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_cnt_nxt == 5'd0);
          end else begin
            state      <= ST_SETTLE;
            idx        <= idx + 4'd1;
            settle_cnt <= '0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bool_sweep_checker.sv
// Randomized self-checking bench: two checkers (SETTLE_CYC=1 and 3) driven by a
// fault-injecting function model and checked against a truth-table reference.
module tb_bool_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2];
  logic        start_s [2];
  logic        fg_s    [2];
  logic        fa_s    [2];
  logic [3:0]  vec_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        pass_s  [2];
  logic [4:0]  cnt_s   [2];
  logic [15:0] map_s   [2];
  logic [3:0]  ffi_s   [2];
  logic        ffv_s   [2];

  // Per-vector fault masks: a set bit flips that implementation's output on that vector.
  logic [15:0] fgm_s [2];
  logic [15:0] fam_s [2];
  logic [15:0] truth_tt;
  bit          glitch_en = 1'b0;
  int          cyc = 0;
  int          k_cyc [2] = '{0, 0};
  int          checks = 0;
  int          failures = 0;

  bool_sweep_checker #(.SETTLE_CYC(1)) u_dut1 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .vec_out(vec_s[0]),
    .fg_in(fg_s[0]), .fa_in(fa_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .pass(pass_s[0]), .fail_cnt(cnt_s[0]), .fail_map(map_s[0]),
    .first_fail_idx(ffi_s[0]), .first_fail_valid(ffv_s[0])
  );

  bool_sweep_checker #(.SETTLE_CYC(3)) u_dut3 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .vec_out(vec_s[1]),
    .fg_in(fg_s[1]), .fa_in(fa_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .pass(pass_s[1]), .fail_cnt(cnt_s[1]), .fail_map(map_s[1]),
    .first_fail_idx(ffi_s[1]), .first_fail_valid(ffv_s[1])
  );

  function automatic logic f_ref(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (b & ~c) | (a & ~c) | (c & d);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Function-under-test model; on the slow checker fa may glitch except in the sampling cycle.
  always @(negedge clk) begin : drive_fut
    logic g;
    for (int i = 0; i < 2; i++) begin
      g = 1'b0;
      if (i == 1 && glitch_en && ((cyc - k_cyc[1] + 1) % 4 != 0)) g = 1'($urandom);
      fg_s[i] = f_ref(vec_s[i]) ^ fgm_s[i][vec_s[i]];
      fa_s[i] = f_ref(vec_s[i]) ^ fam_s[i][vec_s[i]] ^ g;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs(input int s);
    return {31'b0, vec_s[s], busy_s[s], done_s[s], pass_s[s], cnt_s[s],
            map_s[s], ffi_s[s], ffv_s[s]};
  endfunction

  task automatic pulse_start(input int sel);
    @(negedge clk);
    start_s[sel] = 1'b1;
    @(posedge clk);
    #1;
    start_s[sel] = 1'b0;
    k_cyc[sel] = cyc;
  endtask

  // One full sweep; repulse>0 re-asserts start at that cycle offset while busy.
  task automatic run_sweep(input int sel, input int repulse);
    int          hold = (sel == 0) ? 2 : 4;
    logic [15:0] fmap = fgm_s[sel] | fam_s[sel];
    int          ecnt = 0;
    logic [3:0]  efirst = 4'd0;
    bit          evalid = 1'b0;
    bit          vec_ok = 1'b1;
    int          n = 0;
    for (int i = 0; i < 16; i++) begin
      if (fmap[i]) begin
        ecnt++;
        if (!evalid) begin
          efirst = 4'(i);
          evalid = 1'b1;
        end
      end
    end
    pulse_start(sel);
    check("start_clears", outs(sel), {31'b0, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0, 4'd0, 1'b0});
    while (n < 16 * hold + 8) begin
      @(posedge clk);
      #1;
      n++;
      start_s[sel] = (n == repulse);
      if (done_s[sel]) break;
      if (vec_s[sel] !== 4'(n / hold) || busy_s[sel] !== 1'b1) vec_ok = 1'b0;
    end
    start_s[sel] = 1'b0;
    check("vec_step", 64'(vec_ok), 64'd1);
    check("done_at", 64'(n), 64'(16 * hold));
    check("end_vec_busy", {vec_s[sel], busy_s[sel]}, {4'd15, 1'b0});
    check("pass", 64'(pass_s[sel]), 64'(ecnt == 0));
    check("fail_cnt", 64'(cnt_s[sel]), 64'(ecnt));
    check("fail_map", 64'(map_s[sel]), 64'(fmap));
    check("first_fail", {ffv_s[sel], ffi_s[sel]}, {evalid, efirst});
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", {done_s[sel], cnt_s[sel], map_s[sel]}, {1'b1, 5'(ecnt), fmap});
  endtask

  task automatic mid_reset(input int sel, input int off);
    pulse_start(sel);
    repeat (off) @(posedge clk);
    #1;
    rst_s[sel] = 1'b1;
    @(posedge clk);
    #1;
    rst_s[sel] = 1'b0;
    check("mid_reset", outs(sel), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("idle_after_reset", outs(sel), 64'd0);
  endtask

  task automatic random_masks(input int sel);
    fgm_s[sel] = 16'($urandom & $urandom & $urandom);
    fam_s[sel] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom & $urandom);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) truth_tt[i] = f_ref(4'(i));
    for (int i = 0; i < 2; i++) begin
      rst_s[i]   = 1'b1;
      start_s[i] = 1'b0;
      fgm_s[i]   = 16'h0;
      fam_s[i]   = 16'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset1", outs(0), 64'd0);
    check("reset3", outs(1), 64'd0);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Clean implementations.
    run_sweep(0, -1);
    // fa stuck at 0 while fg is correct.
    fam_s[0] = truth_tt;
    run_sweep(0, -1);
    // Restart from a failing DONE into a clean sweep.
    fam_s[0] = 16'h0;
    run_sweep(0, -1);
    // fg and fa agree but are both inverted.
    fgm_s[0] = 16'hFFFF;
    fam_s[0] = 16'hFFFF;
    run_sweep(0, -1);
    // start re-pulsed at vector 5 is ignored.
    random_masks(0);
    run_sweep(0, 10);
    // Reset at vector 7 aborts the sweep.
    mid_reset(0, 14);
    for (int t = 0; t < 6; t++) begin
      random_masks(0);
      run_sweep(0, (t % 2 == 1) ? int'($urandom_range(1, 30)) : -1);
    end

    // Slow checker with fa glitching outside the sampling cycle.
    glitch_en = 1'b1;
    run_sweep(1, -1);
    for (int t = 0; t < 3; t++) begin
      random_masks(1);
      run_sweep(1, int'($urandom_range(1, 62)));
    end
    mid_reset(1, 29);
    glitch_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
